instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/encoder_pkg.sv | 48 ++++
 rtl/instr_fifo.sv | 59 +++++
 rtl/instr_encoder.sv | 134 +++++++++++++
 tb/tb_instr_encoder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types, opcode constants and field-packing helpers for the instruction encoder.
package encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_U  = 3'd2,
        FMT_LI = 3'd3
    } fmt_e;

    typedef enum logic {
        S_ONE,
        S_LI2
    } state_e;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [2:0] FUNCT3_ADDI = 3'b000;

    function automatic logic [31:0] enc_r(input logic [6:0] funct7,
                                          input logic [4:0] rs2,
                                          input logic [4:0] rs1,
                                          input logic [2:0] funct3,
                                          input logic [4:0] rd,
                                          input logic [6:0] opcode);
        return {funct7, rs2, rs1, funct3, rd, opcode};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm,
                                          input logic [4:0]  rs1,
                                          input logic [2:0]  funct3,
                                          input logic [4:0]  rd,
                                          input logic [6:0]  opcode);
        return {imm, rs1, funct3, rd, opcode};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] upper,
                                          input logic [4:0]  rd,
                                          input logic [6:0]  opcode);
        return {upper, rd, opcode};
    endfunction

    // ADDI sign-extends its 12-bit immediate, so the LUI half absorbs bit 11 as a carry.
    function automatic logic [19:0] li_upper(input logic [20:0] imm_hi);
        return imm_hi[20:1] + {19'd0, imm_hi[0]};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of {addr, instr} entries; full is based on the registered count only.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes R/I/U requests into 32-bit words, expands LI into LUI+ADDI, and queues
// each word with its byte address for a ready/valid consumer.
module instr_encoder
    import encoder_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [6:0]        in_funct7,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [7:0]        err_count
);

    state_e              state_q;
    logic [31:0]         addi_q;
    logic [ADDR_W-1:0]   pc_q;
    logic                err_illegal_q;
    logic [7:0]          err_count_q;

    logic                full;
    logic                empty;
    logic [ADDR_W+31:0]  head;
    logic                accept;
    logic                illegal_req;
    logic                li_req;
    logic                push;
    logic [31:0]         push_word;

    assign in_ready    = !reset && (state_q == S_ONE) && !full;
    assign accept      = in_valid && in_ready;
    assign illegal_req = accept && in_fmt[2];
    assign li_req      = accept && (in_fmt == FMT_LI);

    // The pending ADDI is pushed ahead of any new request; in_ready is low meanwhile.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (state_q == S_LI2) begin
            push      = !full;
            push_word = addi_q;
        end else if (accept) begin
            case (fmt_e'(in_fmt))
                FMT_R: begin
                    push      = 1'b1;
                    push_word = enc_r(in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode);
                end
                FMT_I: begin
                    push      = 1'b1;
                    push_word = enc_i(in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode);
                end
                FMT_U: begin
                    push      = 1'b1;
                    push_word = enc_u(in_imm[31:12], in_rd, in_opcode);
                end
                FMT_LI: begin
                    push      = 1'b1;
                    push_word = enc_u(li_upper(in_imm[31:11]), in_rd, OP_LUI);
                end
                default: begin
                    push      = 1'b0;
                    push_word = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_ONE;
            addi_q        <= '0;
            pc_q          <= '0;
            err_illegal_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            err_illegal_q <= illegal_req;
            if (illegal_req && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 1'b1;
            end
            if (push) begin
                pc_q <= pc_q + ADDR_W'(4);
            end
            case (state_q)
                S_ONE: begin
                    if (li_req) begin
                        state_q <= S_LI2;
                        addi_q  <= enc_i(in_imm[11:0], in_rd, FUNCT3_ADDI, in_rd, OP_OP_IMM);
                    end
                end
                S_LI2: begin
                    if (!full) begin
                        state_q <= S_ONE;
                    end
                end
                default: state_q <= S_ONE;
            endcase
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + 32)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({pc_q, push_word}),
        .pop_i       (out_ready),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign out_valid   = !empty;
    assign out_instr   = head[31:0];
    assign out_addr    = head[ADDR_W+31:32];
    assign err_illegal = err_illegal_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed checks of instr_encoder against a queue-based reference model;
// a second instance with ADDR_W=4 shares all inputs to observe address wrap.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [6:0]  in_funct7;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_ready;

    logic        in_ready, out_valid, err_illegal;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic [7:0]  err_count;

    logic        in_ready4, out_valid4, err_illegal4;
    logic [31:0] out_instr4;
    logic [3:0]  out_addr4;
    logic [7:0]  err_count4;

    typedef struct {
        logic [31:0] instr;
        int unsigned addr;
    } word_t;

    word_t       expQueue[$];
    int unsigned modelPc;
    bit          modelLiPending;
    logic [31:0] modelLiWord;
    bit          modelErrPulse;
    int          modelErrCount;
    bit          expReady;
    bit          obsReady;
    bit          obsReady4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct7(in_funct7),
        .in_funct3(in_funct3), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_illegal(err_illegal), .err_count(err_count)
    );

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct7(in_funct7),
        .in_funct3(in_funct3), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .out_valid(out_valid4), .out_ready(out_ready),
        .out_instr(out_instr4), .out_addr(out_addr4),
        .err_illegal(err_illegal4), .err_count(err_count4)
    );

    // Reference encodings built from field weights rather than bit concatenation.
    function automatic logic [31:0] refR(input int unsigned f7, input int unsigned rs2,
                                         input int unsigned rs1, input int unsigned f3,
                                         input int unsigned rd, input int unsigned op);
        int unsigned w;
        w = f7 * 32'd33554432 + rs2 * 32'd1048576 + rs1 * 32'd32768
            + f3 * 32'd4096 + rd * 32'd128 + op;
        return w;
    endfunction

    function automatic logic [31:0] refI(input int unsigned imm12, input int unsigned rs1,
                                         input int unsigned f3, input int unsigned rd,
                                         input int unsigned op);
        int unsigned w;
        w = imm12 * 32'd1048576 + rs1 * 32'd32768 + f3 * 32'd4096 + rd * 32'd128 + op;
        return w;
    endfunction

    function automatic logic [31:0] refU(input int unsigned upper, input int unsigned rd,
                                         input int unsigned op);
        int unsigned w;
        w = upper * 32'd4096 + rd * 32'd128 + op;
        return w;
    endfunction

    // Advance one clock: predict DUT behaviour from current inputs, then update the model.
    task automatic tick();
        logic [31:0] newWords[$];
        int unsigned imm;
        int unsigned sz;
        bit          doPop;
        bit          errNext;
        #1;
        obsReady  = in_ready;
        obsReady4 = in_ready4;
        sz        = expQueue.size();
        expReady  = !reset && !modelLiPending && (sz < DEPTH);
        doPop     = (sz > 0) && out_ready;
        errNext   = 1'b0;
        imm       = in_imm;
        if (!reset) begin
            if (modelLiPending) begin
                if (sz < DEPTH) begin
                    newWords.push_back(modelLiWord);
                    modelLiPending = 1'b0;
                end
            end else if (in_valid && expReady) begin
                case (in_fmt)
                    3'd0: newWords.push_back(refR(in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode));
                    3'd1: newWords.push_back(refI(imm % 4096, in_rs1, in_funct3, in_rd, in_opcode));
                    3'd2: newWords.push_back(refU(imm / 4096, in_rd, in_opcode));
                    3'd3: begin
                        newWords.push_back(refU(((imm / 4096) + ((imm / 2048) % 2)) % 1048576,
                                                in_rd, 32'h37));
                        modelLiWord    = refI(imm % 4096, in_rd, 0, in_rd, 32'h13);
                        modelLiPending = 1'b1;
                    end
                    default: errNext = 1'b1;
                endcase
            end
        end
        @(posedge clk);
        #1;
        if (reset) begin
            expQueue.delete();
            modelPc        = 0;
            modelLiPending = 1'b0;
            modelErrPulse  = 1'b0;
            modelErrCount  = 0;
        end else begin
            if (doPop) void'(expQueue.pop_front());
            foreach (newWords[k]) begin
                expQueue.push_back('{instr: newWords[k], addr: modelPc});
                modelPc = modelPc + 4;
            end
            modelErrPulse = errNext;
            if (errNext && modelErrCount < 255) modelErrCount = modelErrCount + 1;
        end
    endtask

    task automatic set_idle();
        in_valid  = 1'b0;
        in_fmt    = 3'd0;
        in_opcode = '0;
        in_funct7 = '0;
        in_funct3 = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
    endtask

    task automatic set_random_fields();
        in_opcode = 7'($urandom);
        in_funct7 = 7'($urandom);
        in_funct3 = 3'($urandom);
        in_rd     = 5'($urandom);
        in_rs1    = 5'($urandom);
        in_rs2    = 5'($urandom);
        in_imm    = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        out_ready = 1'b1;
        set_random_fields();
        in_valid  = 1'b1;
        in_fmt    = 3'd0;
        tick();
        tick();
        total++; if (obsReady !== 1'b0) $display("[TB] FAIL reset_in_ready got %b want 0", obsReady); else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (err_count !== 8'd0) $display("[TB] FAIL reset_err_count got %0d want 0", err_count); else passed++;
        total++; if (err_illegal !== 1'b0) $display("[TB] FAIL reset_err_illegal got %b want 0", err_illegal); else passed++;
        reset = 1'b0;
        set_idle();
        tick();
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL post_reset_empty got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_rtype();
        do_reset();
        out_ready = 1'b1;
        set_idle();
        in_valid  = 1'b1;
        in_fmt    = 3'd0;
        in_opcode = 7'h33;
        in_rd     = 5'd3;
        in_rs1    = 5'd1;
        in_rs2    = 5'd2;
        tick();
        total++; if (out_valid !== 1'b1) $display("[TB] FAIL rtype_valid got %b want 1", out_valid); else passed++;
        total++; if (out_instr !== 32'h002081B3) $display("[TB] FAIL rtype_instr got %h want 002081b3", out_instr); else passed++;
        total++; if (out_addr !== 10'd0) $display("[TB] FAIL rtype_addr got %0d want 0", out_addr); else passed++;
        set_idle();
        tick();
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL rtype_drained got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_li();
        do_reset();
        out_ready = 1'b1;
        set_random_fields();
        in_valid  = 1'b1;
        in_fmt    = 3'd3;
        in_rd     = 5'd5;
        in_imm    = 32'h12345FFF;
        tick();
        total++; if (out_instr !== 32'h123462B7) $display("[TB] FAIL li_lui_instr got %h want 123462b7", out_instr); else passed++;
        total++; if (out_addr !== 10'd0) $display("[TB] FAIL li_lui_addr got %0d want 0", out_addr); else passed++;
        in_fmt = 3'd0;
        tick();
        total++; if (obsReady !== 1'b0) $display("[TB] FAIL li2_in_ready got %b want 0", obsReady); else passed++;
        total++; if (out_instr !== 32'hFFF28293) $display("[TB] FAIL li_addi_instr got %h want fff28293", out_instr); else passed++;
        total++; if (out_addr !== 10'd4) $display("[TB] FAIL li_addi_addr got %0d want 4", out_addr); else passed++;
        set_idle();
        tick();
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL li_drained got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        int accepted;
        do_reset();
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_random_fields();
            in_valid = 1'b1;
            in_fmt   = 3'd0;
            tick();
            if (obsReady) accepted++;
            total++;
            if (out_valid && (out_instr !== expQueue[0].instr || out_addr !== 10'd0))
                $display("[TB] FAIL bp_head_hold got %h@%0d want %h@0", out_instr, out_addr, expQueue[0].instr);
            else passed++;
        end
        total++; if (accepted != DEPTH) $display("[TB] FAIL bp_accepted got %0d want %0d", accepted, DEPTH); else passed++;
        total++; if (obsReady !== 1'b0) $display("[TB] FAIL bp_full_ready got %b want 0", obsReady); else passed++;
        set_idle();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_addr !== 10'(i * 4) || expQueue.size() == 0 || out_instr !== expQueue[0].instr)
                $display("[TB] FAIL bp_drain_%0d got v=%b %h@%0d want addr %0d", i, out_valid, out_instr, out_addr, i * 4);
            else passed++;
            tick();
        end
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_empty got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            set_random_fields();
            in_valid = 1'b1;
            in_fmt   = 3'd5;
            tick();
            total++; if (err_illegal !== 1'b1) $display("[TB] FAIL illegal_pulse_%0d got %b want 1", n, err_illegal); else passed++;
            total++; if (out_valid !== 1'b0) $display("[TB] FAIL illegal_no_word_%0d got %b want 0", n, out_valid); else passed++;
            set_idle();
            tick();
            total++; if (err_illegal !== 1'b0) $display("[TB] FAIL illegal_pulse_end_%0d got %b want 0", n, err_illegal); else passed++;
        end
        total++; if (err_count !== 8'd2) $display("[TB] FAIL illegal_count got %0d want 2", err_count); else passed++;
        for (int n = 0; n < 300; n++) begin
            set_random_fields();
            in_valid = 1'b1;
            in_fmt   = 3'($urandom_range(4, 7));
            tick();
        end
        set_idle();
        tick();
        total++; if (err_count !== 8'd255) $display("[TB] FAIL illegal_saturate got %0d want 255", err_count); else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL illegal_no_words got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_random_fields();
            in_valid = 1'b1;
            in_fmt   = 3'd0;
            tick();
            total++;
            if (out_valid4 !== 1'b1 || out_addr4 !== 4'((k * 4) % 16))
                $display("[TB] FAIL wrap_addr_%0d got v=%b %0d want %0d", k, out_valid4, out_addr4, (k * 4) % 16);
            else passed++;
            total++;
            if (out_addr !== 10'(k * 4)) $display("[TB] FAIL wide_addr_%0d got %0d want %0d", k, out_addr, k * 4);
            else passed++;
        end
        set_idle();
        tick();
    endtask

    task automatic test_reset_li2();
        do_reset();
        out_ready = 1'b1;
        set_random_fields();
        in_valid  = 1'b1;
        in_fmt    = 3'd3;
        tick();
        set_idle();
        reset = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL li2_reset_valid got %b want 0", out_valid); else passed++;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) $display("[TB] FAIL li2_no_addi_%0d got %b want 0", i, out_valid); else passed++;
        end
        set_random_fields();
        in_valid = 1'b1;
        in_fmt   = 3'd0;
        tick();
        total++; if (out_valid !== 1'b1 || out_addr !== 10'd0) $display("[TB] FAIL li2_pc_reset got v=%b %0d want addr 0", out_valid, out_addr); else passed++;
        set_idle();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 63) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            set_random_fields();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_fmt    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            tick();
            total++; if (obsReady !== expReady || obsReady4 !== expReady)
                $display("[TB] FAIL rand_ready_%0d got %b/%b want %b", c, obsReady, obsReady4, expReady); else passed++;
            total++; if (out_valid !== (expQueue.size() != 0) || out_valid4 !== (expQueue.size() != 0))
                $display("[TB] FAIL rand_valid_%0d got %b/%b want %b", c, out_valid, out_valid4, expQueue.size() != 0); else passed++;
            if (expQueue.size() != 0) begin
                total++;
                if (out_instr !== expQueue[0].instr || out_instr4 !== expQueue[0].instr ||
                    out_addr !== 10'(expQueue[0].addr % 1024) || out_addr4 !== 4'(expQueue[0].addr % 16))
                    $display("[TB] FAIL rand_head_%0d got %h@%0d/%0d want %h@%0d", c, out_instr, out_addr,
                             out_addr4, expQueue[0].instr, expQueue[0].addr % 1024);
                else passed++;
            end
            total++; if (err_illegal !== modelErrPulse || err_illegal4 !== modelErrPulse)
                $display("[TB] FAIL rand_err_pulse_%0d got %b want %b", c, err_illegal, modelErrPulse); else passed++;
            total++; if (err_count !== 8'(modelErrCount) || err_count4 !== 8'(modelErrCount))
                $display("[TB] FAIL rand_err_count_%0d got %0d want %0d", c, err_count, modelErrCount); else passed++;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        out_ready      = 1'b0;
        modelPc        = 0;
        modelLiPending = 1'b0;
        modelLiWord    = '0;
        modelErrPulse  = 1'b0;
        modelErrCount  = 0;
        set_idle();
        test_reset();
        test_rtype();
        test_li();
        test_backpressure();
        test_illegal();
        test_wrap();
        test_reset_li2();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
